// File: rtl/field_hdr_tx_module_pkg.sv
// Shared definitions for the header transmit path: field widths, packing
// order of the header fields, derived header length and the transmit FSM states.
package field_hdr_tx_module_pkg;

   localparam int FIELD_BT8_BITS   = 8;
   localparam int FIELD_PID1_BITS  = 4;
   localparam int FIELD_MC1_BITS   = 4;
   localparam int FIELD_MT1_BITS   = 4;
   localparam int FIELD_SS5_BITS   = 4;
   localparam int FIELD_EB3_BITS   = 4;
   localparam int FIELD_SPDC1_BITS = 4;
   localparam int FIELD_SP4_BITS   = 4;
   localparam int FIELD_V4_BITS    = 4;
   localparam int FIELD_PPDC1_BITS = 4;
   localparam int FIELD_PP4_BITS   = 4;
   localparam int FIELD_TI4_BITS   = 4;
   localparam int FIELD_OIV4_BITS  = 4;
   localparam int FIELD_BP4_BITS   = 4;
   localparam int FIELD_BS4_BITS   = 4;
   localparam int FIELD_OP4_BITS   = 4;
   localparam int FIELD_OS4_BITS   = 4;
   localparam int FIELD_SS4_BITS   = 4;
   localparam int FIELD_SP2_BITS   = 4;
   localparam int FIELD_BP2_BITS   = 4;
   localparam int FIELD_BS2_BITS   = 4;
   localparam int FIELD_OP2_BITS   = 4;
   localparam int FIELD_OS2_BITS   = 4;
   localparam int FIELD_BSN4_BITS  = 8;
   localparam int FIELD_EBSN4_BITS = 8;
   localparam int FIELD_RBSN4_BITS = 8;
   localparam int FIELD_MC8_BITS   = 8;

   // Member order is the on-wire order: the first member lands at the MSBs.
   typedef struct packed {
      logic [FIELD_BT8_BITS-1:0]   bt8;
      logic [FIELD_PID1_BITS-1:0]  pid1;
      logic [FIELD_MC1_BITS-1:0]   mc1;
      logic [FIELD_MT1_BITS-1:0]   mt1;
      logic [FIELD_SS5_BITS-1:0]   ss5;
      logic [FIELD_EB3_BITS-1:0]   eb3;
      logic [FIELD_SPDC1_BITS-1:0] spdc1;
      logic [FIELD_SP4_BITS-1:0]   sp4;
      logic [FIELD_V4_BITS-1:0]    v4;
      logic [FIELD_PPDC1_BITS-1:0] ppdc1;
      logic [FIELD_PP4_BITS-1:0]   pp4;
      logic [FIELD_TI4_BITS-1:0]   ti4;
      logic [FIELD_OIV4_BITS-1:0]  oiv4;
      logic [FIELD_BP4_BITS-1:0]   bp4;
      logic [FIELD_BS4_BITS-1:0]   bs4;
      logic [FIELD_OP4_BITS-1:0]   op4;
      logic [FIELD_OS4_BITS-1:0]   os4;
      logic [FIELD_SS4_BITS-1:0]   ss4;
      logic [FIELD_SP2_BITS-1:0]   sp2;
      logic [FIELD_BP2_BITS-1:0]   bp2;
      logic [FIELD_BS2_BITS-1:0]   bs2;
      logic [FIELD_OP2_BITS-1:0]   op2;
      logic [FIELD_OS2_BITS-1:0]   os2;
      logic [FIELD_BSN4_BITS-1:0]  bsn4;
      logic [FIELD_EBSN4_BITS-1:0] ebsn4;
      logic [FIELD_RBSN4_BITS-1:0] rbsn4;
      logic [FIELD_MC8_BITS-1:0]   mc8;
   } hdr_fields_t;

   localparam int HDR_FIELD_BITS = $bits(hdr_fields_t);
   localparam int HDR_BYTES_DEF  = (HDR_FIELD_BITS + 7) / 8;
   localparam int HDR_W          = HDR_BYTES_DEF * 8;
   localparam int HDR_PAD_BITS   = HDR_W - HDR_FIELD_BITS;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

endpackage

// File: rtl/field_hdr_pack_module.sv
// Concatenates the last field-register stage outputs into one packed header,
// BT8 at the MSBs and zero padding at the LSBs up to a whole byte.
module field_hdr_pack_module
   import field_hdr_tx_module_pkg::*;
(
   input  hdr_fields_t       fields,
   output logic [HDR_W-1:0]  hdr_data
);

   // Shifting instead of concatenating keeps this legal when no padding is needed.
   assign hdr_data = HDR_W'(fields) << HDR_PAD_BITS;

endmodule

// File: rtl/field_hdr_tx_module.sv
// Serialises one packed header per handshake onto a byte stream, MSB first,
// with SOP/EOP markers and a wrapping count of completed headers.
module field_hdr_tx_module
   import field_hdr_tx_module_pkg::*;
#(
   parameter int HDR_BYTES = 16,
   parameter int CNT_W     = 6,
   parameter int FCNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [HDR_BYTES*8-1:0] hdr_data,
   input  logic                   hdr_valid,
   output logic                   hdr_ready,
   output logic [7:0]             byte_out,
   output logic                   byte_valid,
   input  logic                   byte_ready,
   output logic                   byte_sop,
   output logic                   byte_eop,
   output logic [FCNT_W-1:0]      hdr_cnt
);

   localparam int              TOP      = HDR_BYTES * 8 - 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_BYTES - 1);

   tx_state_t                state;
   logic [HDR_BYTES*8-1:0]   shift_reg;
   logic [HDR_BYTES*8-1:0]   shifted;
   logic [CNT_W-1:0]         byte_idx;
   logic                     load;
   logic                     byte_take;

   // A new header may enter when idle, or in the very cycle the last byte leaves.
   assign hdr_ready = (state == IDLE) | (byte_eop & byte_valid & byte_ready);
   assign load      = hdr_valid & hdr_ready;
   assign byte_take = byte_valid & byte_ready;
   assign shifted   = shift_reg << 8;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_reg  <= '0;
         byte_idx   <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         byte_sop   <= 1'b0;
         byte_eop   <= 1'b0;
         hdr_cnt    <= '0;
      end else begin
         if (byte_take && byte_eop) begin
            hdr_cnt <= hdr_cnt + FCNT_W'(1);
         end
         if (load) begin
            state      <= SEND;
            shift_reg  <= hdr_data;
            byte_out   <= hdr_data[TOP -: 8];
            byte_idx   <= '0;
            byte_valid <= 1'b1;
            byte_sop   <= 1'b1;
            byte_eop   <= (HDR_BYTES == 1);
         end else if (byte_take) begin
            if (byte_eop) begin
               state      <= IDLE;
               byte_valid <= 1'b0;
               byte_sop   <= 1'b0;
               byte_eop   <= 1'b0;
            end else begin
               shift_reg <= shifted;
               byte_out  <= shifted[TOP -: 8];
               byte_idx  <= byte_idx + CNT_W'(1);
               byte_sop  <= 1'b0;
               byte_eop  <= ((byte_idx + CNT_W'(1)) == LAST_IDX);
            end
         end
      end
   end

endmodule
